demux_stream: RTL and testbench
===============================

// Module: demux_stream
// PURPOSE
//  Parametrised, registered 1-to-N stream demultiplexer with valid/ready flow control.
//  One input beat is steered to one of N_OUT output channels by select s.
//  Each output channel holds one registered beat until its consumer accepts it.
//  Sits between a single producer and N independent consumers. Replaces the combinational 1:4 demux.
// PARAMETERS
//  DATA_W  8  width of one data beat
//  N_OUT   4  number of output channels, 2..16
//  SEL_W   2  select width; N_OUT <= 2**SEL_W is required
// PORTS
//  clk       in   1             rising-edge clock
//  rst       in   1             asynchronous active-high reset
//  i         in   DATA_W        input data beat
//  i_valid   in   1             input beat present
//  i_ready   out  1             block accepts the beat this cycle
//  i_last    in   1             last beat of packet (used only with DEMUX_PKT_LOCK_EN)
//  s         in   SEL_W         destination channel, sampled with the beat
//  op        out  N_OUT*DATA_W  channel k data is op[k*DATA_W +: DATA_W]
//  op_valid  out  N_OUT         channel k holds a beat
//  op_ready  in   N_OUT         consumer k accepts its beat
//  err       out  1             one-cycle pulse: beat dropped because of an illegal select
//  drop_cnt  out  8             count of dropped beats, saturates at 255
// BEHAVIOUR
//  - Reset (async assert, sync release): op_valid=0, op=0, err=0, drop_cnt=0, lock state cleared.
//  - Accept: a beat is taken when i_valid && i_ready. Output stays registered; beat appears at op_valid[s] one cycle after accept.
//  - Select s is legal when s < N_OUT. i_ready = slot_free[s] for a legal s; i_ready = 1 for an illegal s.
//  - slot_free[k] = !op_valid[k] || op_ready[k]. This allows same-cycle drain and refill, so each channel sustains 1 beat/clk.
//  - Channel k on a clock edge:
//    - accept to k: op_valid[k]<=1 and its data is loaded.
//    - else if op_ready[k]: op_valid[k]<=0.
//    - else: the channel holds.
//  - Stall isolation: a full channel never blocks beats addressed to other channels.
//  - op data of a channel is stable while op_valid=1 and op_ready=0. Data of an empty channel is don't-care; it keeps its last value.
//  - Illegal select: the beat is consumed and dropped. err pulses the next cycle and drop_cnt increments; at 255 it stays at 255.
//  - Only the selected channel changes. Other channels are unaffected by i and s.
//  - N_OUT < 2**SEL_W: the select codes N_OUT..2**SEL_W-1 are illegal.
//  - Reset mid-transfer discards every held beat with no output pulse.
// CONFIGURATION
//  DEMUX_PKT_LOCK_EN defined: packet mode with FSM IDLE/LOCKED.
//    - IDLE: s is sampled on the first accepted beat. If i_last=0 the FSM goes to LOCKED with lock_sel=s.
//    - LOCKED: every beat routes to lock_sel and s is ignored. The FSM returns to IDLE when a beat with i_last=1 is accepted.
//    - A one-beat packet (i_last=1 in IDLE) stays IDLE.
//    - An illegal s at packet start drops the whole packet. err pulses once; drop_cnt counts every beat.
//  DEMUX_PKT_LOCK_EN undefined: per-beat routing as above. i_last is ignored and no FSM is built.
// TESTING
//  1 Reset: assert rst mid-stream holding beats on ch0,ch2 -> op_valid=0, drop_cnt=0 asynchronously.
//  2 Routing: beats 0xA1,s=0; 0xB2,s=1; 0xC3,s=3 with op_ready=4'hF -> each appears on its own channel 1 cycle later.
//  3 Backpressure: op_ready[1]=0, two beats s=1 -> first held, i_ready=0 for the second; a beat to s=2 is still accepted the same cycle.
//  4 Throughput: continuous beats to s=2 with op_ready[2]=1 -> 1 beat/clk, no bubbles, data in order.
//  5 Illegal select, N_OUT=3: beat with s=3 -> i_ready=1, err pulse, drop_cnt=1; 300 such beats -> drop_cnt=255.
//  6 Lock (DEMUX_PKT_LOCK_EN): 4-beat packet, s=1 on beat 0, s toggles 0/2 afterwards -> all 4 beats on ch1; the next packet follows its new s.

Source files
------------

// File: rtl/demux_stream.sv
`default_nettype none
// ============================================================================
//  Module      : demux_stream
//  Description : Registered 1-to-N_OUT stream demultiplexer with valid/ready
//                flow control. One input beat is steered by select s into a
//                one-beat holding register per output channel. Beats whose
//                select is out of range are consumed and dropped; err pulses
//                and a saturating drop counter records them.
//                Optional macro DEMUX_PKT_LOCK_EN enables packet mode: the
//                select is sampled on the first beat of a packet and held
//                until the beat carrying i_last is accepted.
//  Revision    : 1.0 - initial release
// ============================================================================
module demux_stream #(
    parameter int DATA_W = 8,
    parameter int N_OUT  = 4,
    parameter int SEL_W  = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [DATA_W-1:0]       i,
    input  logic                    i_valid,
    output logic                    i_ready,
    input  logic                    i_last,
    input  logic [SEL_W-1:0]        s,
    output logic [N_OUT*DATA_W-1:0] op,
    output logic [N_OUT-1:0]        op_valid,
    input  logic [N_OUT-1:0]        op_ready,
    output logic                    err,
    output logic [7:0]              drop_cnt
);

    // One extra bit so N_OUT == 2**SEL_W is representable in the compare.
    localparam logic [SEL_W:0] c_N_OUT = (SEL_W + 1)'(N_OUT);

    logic [SEL_W-1:0] w_sel;        // effective destination this cycle
    logic             w_pkt_start;  // beat is the first of a packet
    logic             w_legal;
    logic             w_sel_free;
    logic             w_accept;
    logic             w_drop;
    logic [N_OUT-1:0] w_slot_free;
    logic [N_OUT-1:0] w_load;
    logic             r_err;
    logic [7:0]       r_drop_cnt;

`ifdef DEMUX_PKT_LOCK_EN
    localparam logic [0:0] c_ST_IDLE   = 1'b0;
    localparam logic [0:0] c_ST_LOCKED = 1'b1;

    logic [0:0]       r_state;
    logic [0:0]       w_state_next;
    logic [SEL_W-1:0] r_lock_sel;
    logic [SEL_W-1:0] w_lock_sel_next;

    // Packet FSM state and latched destination register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= c_ST_IDLE;
            r_lock_sel <= '0;
        end else begin
            r_state    <= w_state_next;
            r_lock_sel <= w_lock_sel_next;
        end
    end

    // Lock on a multi-beat packet start, unlock on its last accepted beat
    always_comb begin
        w_state_next    = r_state;
        w_lock_sel_next = r_lock_sel;
        case (r_state)
            c_ST_IDLE: begin
                if (w_accept && !i_last) begin
                    w_state_next    = c_ST_LOCKED;
                    w_lock_sel_next = s;
                end
            end
            c_ST_LOCKED: begin
                if (w_accept && i_last) begin
                    w_state_next = c_ST_IDLE;
                end
            end
            default: w_state_next = c_ST_IDLE;
        endcase
    end

    // An illegal latched select keeps dropping until the packet ends.
    assign w_sel       = (r_state == c_ST_LOCKED) ? r_lock_sel : s;
    assign w_pkt_start = (r_state == c_ST_IDLE);
`else
    logic w_unused_last;

    assign w_sel         = s;
    assign w_pkt_start   = 1'b1;
    assign w_unused_last = i_last;
`endif

    assign w_legal     = {1'b0, w_sel} < c_N_OUT;
    assign w_slot_free = ~op_valid | op_ready;

    // Free state of the addressed slot; stays 0 for out-of-range selects
    always_comb begin
        w_sel_free = 1'b0;
        for (int k = 0; k < N_OUT; k++) begin
            if (w_sel == SEL_W'(k)) begin
                w_sel_free = w_slot_free[k];
            end
        end
    end

    // Illegal beats are always taken so they never stall the producer.
    assign i_ready  = w_legal ? w_sel_free : 1'b1;
    assign w_accept = i_valid && i_ready;
    assign w_drop   = w_accept && !w_legal;

    for (genvar k = 0; k < N_OUT; k++) begin : g_chan
        logic              r_valid;
        logic [DATA_W-1:0] r_data;

        assign w_load[k] = w_accept && w_legal && (w_sel == SEL_W'(k));

        // Holding register: refill wins over drain, data frozen otherwise
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_valid <= 1'b0;
                r_data  <= '0;
            end else if (w_load[k]) begin
                r_valid <= 1'b1;
                r_data  <= i;
            end else if (op_ready[k]) begin
                r_valid <= 1'b0;
            end
        end

        assign op_valid[k]               = r_valid;
        assign op[k*DATA_W +: DATA_W]    = r_data;
    end

    // Drop reporting: err once per dropped packet, counter per dropped beat
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err      <= 1'b0;
            r_drop_cnt <= 8'd0;
        end else begin
            r_err <= w_drop && w_pkt_start;
            if (w_drop && (r_drop_cnt != 8'hFF)) begin
                r_drop_cnt <= r_drop_cnt + 8'd1;
            end
        end
    end

    assign err      = r_err;
    assign drop_cnt = r_drop_cnt;

endmodule
`default_nettype wire

// File: tb/tb_demux_stream.sv
`default_nettype none
// ============================================================================
//  Module      : tb_demux_stream
//  Description : Randomised and directed bench for demux_stream (N_OUT=3,
//                SEL_W=2 so select 3 is illegal). Expected beats go into
//                per-channel queues; a monitor pops them on each handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_demux_stream;

    localparam int DW = 8;
    localparam int NO = 3;
    localparam int SW = 2;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [DW-1:0]     i_data = '0;
    logic              i_valid = 1'b0;
    logic              i_ready;
    logic              i_last = 1'b0;
    logic [SW-1:0]     s = '0;
    logic [NO*DW-1:0]  op;
    logic [NO-1:0]     op_valid;
    logic [NO-1:0]     op_ready = '0;
    logic              err;
    logic [7:0]        drop_cnt;

    demux_stream #(.DATA_W(DW), .N_OUT(NO), .SEL_W(SW)) dut (
        .clk      (clk),
        .rst      (rst),
        .i        (i_data),
        .i_valid  (i_valid),
        .i_ready  (i_ready),
        .i_last   (i_last),
        .s        (s),
        .op       (op),
        .op_valid (op_valid),
        .op_ready (op_ready),
        .err      (err),
        .drop_cnt (drop_cnt)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model: beats held per channel, expected err / counter,
    // and the packet-lock state as a plain flag plus latched select.
    logic [DW-1:0] q[NO][$];
    logic          m_err      = 1'b0;
    int            m_drop     = 0;
    logic          m_locked   = 1'b0;
    logic [SW-1:0] m_lock_sel = '0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, exp, $time);
        end
    endtask

    // One clock of stimulus; model checks and updates happen at the negedge.
    task automatic cycle(input logic v, input logic [SW-1:0] sel, input logic [DW-1:0] d,
                         input logic last, input logic [NO-1:0] rdy);
        logic [SW-1:0] eff;
        logic          legal;
        logic          exp_rdy;
        logic          acc;
        @(posedge clk);
        #1;
        i_valid  = v;
        s        = sel;
        i_data   = d;
        i_last   = last;
        op_ready = rdy;
        @(negedge clk);
        for (int k = 0; k < NO; k++)
            chk($sformatf("op_valid[%0d]", k), int'(op_valid[k]), int'(q[k].size() != 0));
        chk("err", int'(err), int'(m_err));
        chk("drop_cnt", int'(drop_cnt), m_drop);
        eff     = m_locked ? m_lock_sel : sel;
        legal   = int'(eff) < NO;
        exp_rdy = 1'b1;
        if (legal) exp_rdy = (q[eff].size() == 0) || rdy[eff];
        chk("i_ready", int'(i_ready), int'(exp_rdy));
        acc   = v && exp_rdy;
        m_err = acc && !legal && !m_locked;
        if (acc && !legal && m_drop < 255) m_drop++;
        if (acc && legal) q[eff].push_back(d);
`ifdef DEMUX_PKT_LOCK_EN
        if (acc) begin
            if (!m_locked && !last) begin
                m_locked   = 1'b1;
                m_lock_sel = sel;
            end else if (m_locked && last) begin
                m_locked = 1'b0;
            end
        end
`endif
    endtask

    // Monitor: compare presented data with the queue head, pop on handshake
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (!rst) begin
                for (int k = 0; k < NO; k++) begin
                    if (op_valid[k]) begin
                        if (q[k].size() == 0) begin
                            chk($sformatf("spurious_valid[%0d]", k), 1, 0);
                        end else begin
                            chk($sformatf("op[%0d]", k), int'(op[k*DW +: DW]), int'(q[k][0]));
                            if (op_ready[k]) void'(q[k].pop_front());
                        end
                    end
                end
            end
        end
    end

    initial begin
        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_op_valid", int'(op_valid), 0);
        chk("rst_op", int'(op), 0);
        chk("rst_err", int'(err), 0);
        chk("rst_drop_cnt", int'(drop_cnt), 0);
        rst = 1'b0;

        // Routing to each legal channel
        cycle(1'b1, 2'd0, 8'hA1, 1'b1, 3'b111);
        cycle(1'b1, 2'd1, 8'hB2, 1'b1, 3'b111);
        cycle(1'b1, 2'd2, 8'hC3, 1'b1, 3'b111);
        cycle(1'b0, 2'd0, 8'h00, 1'b1, 3'b111);

        // Backpressure on ch1, ch2 still accepted
        cycle(1'b1, 2'd1, 8'h11, 1'b1, 3'b101);
        cycle(1'b1, 2'd1, 8'h22, 1'b1, 3'b101);
        cycle(1'b1, 2'd2, 8'h33, 1'b1, 3'b101);
        cycle(1'b1, 2'd1, 8'h22, 1'b1, 3'b101);
        cycle(1'b0, 2'd0, 8'h00, 1'b1, 3'b111);

        // Sustained 1 beat/clk to ch2
        for (int j = 0; j < 20; j++)
            cycle(1'b1, 2'd2, DW'(8'h40 + j), 1'b1, 3'b111);
        cycle(1'b0, 2'd0, 8'h00, 1'b1, 3'b111);

        // Illegal select: single drop, then saturation
        cycle(1'b1, 2'd3, 8'hEE, 1'b1, 3'b111);
        cycle(1'b0, 2'd0, 8'h00, 1'b1, 3'b111);
        for (int j = 0; j < 300; j++)
            cycle(1'b1, 2'd3, DW'(j), 1'b1, 3'b111);
        cycle(1'b0, 2'd0, 8'h00, 1'b1, 3'b111);
        cycle(1'b0, 2'd0, 8'h00, 1'b1, 3'b111);

`ifdef DEMUX_PKT_LOCK_EN
        // Packet lock: 4 beats on ch1 despite s toggling, next packet on ch2
        cycle(1'b1, 2'd1, 8'hD0, 1'b0, 3'b111);
        cycle(1'b1, 2'd0, 8'hD1, 1'b0, 3'b111);
        cycle(1'b1, 2'd2, 8'hD2, 1'b0, 3'b111);
        cycle(1'b1, 2'd0, 8'hD3, 1'b1, 3'b111);
        cycle(1'b1, 2'd2, 8'hE0, 1'b1, 3'b111);
        cycle(1'b0, 2'd0, 8'h00, 1'b1, 3'b111);
`endif

        // Mid-stream reset with beats held on ch0 and ch2
        cycle(1'b1, 2'd0, 8'h5A, 1'b1, 3'b000);
        cycle(1'b1, 2'd2, 8'h6B, 1'b1, 3'b000);
        cycle(1'b0, 2'd0, 8'h00, 1'b1, 3'b000);
        #1;
        rst = 1'b1;
        #1;
        chk("async_rst_op_valid", int'(op_valid), 0);
        chk("async_rst_drop_cnt", int'(drop_cnt), 0);
        chk("async_rst_err", int'(err), 0);
        for (int k = 0; k < NO; k++) q[k].delete();
        m_err    = 1'b0;
        m_drop   = 0;
        m_locked = 1'b0;
        @(negedge clk);
        rst = 1'b0;

        // Randomised traffic
        for (int j = 0; j < 2000; j++)
            cycle($urandom_range(0, 3) != 0, SW'($urandom_range(0, 3)), DW'($urandom),
                  1'($urandom_range(0, 1)), NO'($urandom));

        // Drain and confirm every expected beat was delivered
        repeat (4) cycle(1'b0, 2'd0, 8'h00, 1'b1, 3'b111);
        #3;
        for (int k = 0; k < NO; k++)
            chk($sformatf("drain_q[%0d]", k), q[k].size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
